cpu_clock_ctrl: RTL and testbench

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

---
 rtl/cpu_clock_pkg.sv | 11 +
 rtl/btn_debounce.sv | 29 ++
 rtl/cpu_clock_ctrl.sv | 56 +++++
 tb/tb_cpu_clock_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clock_pkg.sv
// cpu_clock_pkg: state encodings, mode codes and SLOW rate table shared by the CPU clock controller
package cpu_clock_pkg;
  localparam logic [2:0] ST_HALTED = 3'd0, ST_STEP = 3'd1, ST_SLOW = 3'd2, ST_FAST = 3'd3, ST_STOPPED = 3'd4;
  localparam logic [1:0] MODE_HALT = 2'b00, MODE_STEP = 2'b01, MODE_SLOW = 2'b10, MODE_FAST = 2'b11;
  function automatic int unsigned slow_rate(input logic [1:0] sel);
    return sel == 2'b00 ? 1 : sel == 2'b01 ? 2 : sel == 2'b10 ? 5 : 10;
  endfunction
  function automatic logic [2:0] mode_state(input logic [1:0] m);
    return m == MODE_FAST ? ST_FAST : m == MODE_SLOW ? ST_SLOW : m == MODE_STEP ? ST_STEP : ST_HALTED;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, level debounce and one-cycle press pulse for a raw push-button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, level, done;
  logic [CW-1:0] cnt;
  // cnt tracks consecutive synchronized samples that disagree with the accepted level
  assign done = s2 != level && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      cnt <= s2 == level || done ? '0 : cnt + CW'(1);
      level <= done ? s2 : level;
      pulse <= done && s2;
    end
endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: run-mode FSM issuing registered cpu_ce pulses in HALT/STEP/SLOW/FAST modes
module cpu_clock_ctrl import cpu_clock_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic [1:0]  div_sel,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic [31:0] cycle_count,
  output logic [2:0]  state,
  output logic        led_tick
);
  localparam logic [31:0] DIV_N [4] = '{
    32'(CLK_HZ / slow_rate(2'd0)), 32'(CLK_HZ / slow_rate(2'd1)),
    32'(CLK_HZ / slow_rate(2'd2)), 32'(CLK_HZ / slow_rate(2'd3))
  };
  logic step_pulse, div_chg, slow_hit, ce_nxt;
  logic [1:0] div_q;
  logic [31:0] div_cnt;
  logic [2:0] state_nxt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk_50M),
    .rst_n(rst_n),
    .btn(step_btn),
    .pulse(step_pulse)
  );
  // cpu_ce is registered from the next state so it never outlives a mode change or halt
  always_comb begin
    state_nxt = state == ST_STOPPED ? (mode == MODE_HALT ? ST_HALTED : ST_STOPPED)
              : cpu_ce && halt_req ? ST_STOPPED : mode_state(mode);
    div_chg = div_sel != div_q;
    slow_hit = div_cnt == DIV_N[div_sel] - 32'd1;
    ce_nxt = state_nxt == ST_FAST || (state == state_nxt &&
             ((state == ST_STEP && step_pulse) || (state == ST_SLOW && !div_chg && slow_hit)));
  end
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      state <= ST_HALTED;
      cpu_ce <= 1'b0;
      cycle_count <= '0;
      led_tick <= 1'b0;
      div_cnt <= '0;
      div_q <= '0;
    end else begin
      state <= state_nxt;
      cpu_ce <= ce_nxt;
      cycle_count <= cycle_count + {31'd0, cpu_ce && ~&cycle_count};
      led_tick <= led_tick ^ cpu_ce;
      div_q <= div_sel;
      div_cnt <= state_nxt != state || div_chg || slow_hit ? '0 : div_cnt + 32'd1;
    end
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: directed scenarios plus random traffic against a behavioural model and pulse scoreboard
module tb_cpu_clock_ctrl;
  import cpu_clock_pkg::*;
  localparam int HZ = 100, DB = 4;
  logic clk_50M = 0, rst_n = 0, step_btn = 0, halt_req = 0;
  logic [1:0] mode = 0, div_sel = 0;
  logic cpu_ce, led_tick;
  logic [31:0] cycle_count;
  logic [2:0] state;
  int tests = 0, fails = 0, n, ces;
  int unsigned cyc = 0;
  typedef struct { int unsigned cyc; logic [31:0] cnt; logic [2:0] st; } exp_t;
  exp_t sb[$];
  int rates[4] = '{1, 2, 5, 10};
  logic [2:0] m_st = ST_HALTED;
  logic m_ce = 0, m_led = 0, m_pulse = 0, m_lvl = 0;
  logic [31:0] m_cnt = 0;
  logic [1:0] m_div = 0;
  int m_since = 0;
  logic raw[$], syn[$];

  cpu_clock_ctrl #(.CLK_HZ(HZ), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .mode(mode), .div_sel(div_sel), .step_btn(step_btn),
    .halt_req(halt_req), .cpu_ce(cpu_ce), .cycle_count(cycle_count), .state(state), .led_tick(led_tick)
  );

  always #5 clk_50M = ~clk_50M;

  function automatic logic [2:0] mode_st(input logic [1:0] m);
    case (m)
      2'b00: return ST_HALTED;
      2'b01: return ST_STEP;
      2'b10: return ST_SLOW;
      default: return ST_FAST;
    endcase
  endfunction

  // Reference model: SLOW pulses fall on multiples of N since the last epoch start; debounce is a sample window
  always @(posedge clk_50M or negedge rst_n) begin : model
    logic [2:0] nst;
    logic ce, dchg, s, all;
    exp_t e;
    if (!rst_n) begin
      m_st = ST_HALTED; m_ce = 0; m_led = 0; m_pulse = 0; m_lvl = 0; m_cnt = 0; m_div = 0; m_since = 0;
      raw.delete(); syn.delete(); sb.delete();
    end else begin
      cyc++;
      nst = m_st == ST_STOPPED ? (mode == 2'b00 ? ST_HALTED : ST_STOPPED)
          : (m_ce && halt_req) ? ST_STOPPED : mode_st(mode);
      dchg = div_sel != m_div;
      m_div = div_sel;
      m_since = (nst == ST_SLOW && (m_st != ST_SLOW || dchg)) ? 0 : m_since + 1;
      ce = nst == ST_FAST || (m_st == ST_STEP && nst == ST_STEP && m_pulse) ||
           (m_st == ST_SLOW && nst == ST_SLOW && !dchg && m_since % (HZ / rates[div_sel]) == 0);
      if (m_ce && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      m_led ^= m_ce;
      m_ce = ce;
      m_st = nst;
      if (ce) begin e.cyc = cyc; e.cnt = m_cnt; e.st = nst; sb.push_back(e); end
      s = raw.size() >= 2 ? raw[raw.size() - 2] : 1'b0;
      raw.push_back(step_btn);
      if (raw.size() > 4) void'(raw.pop_front());
      syn.push_back(s);
      if (syn.size() > DB) void'(syn.pop_front());
      all = syn.size() == DB;
      foreach (syn[i]) if (syn[i] == m_lvl) all = 0;
      m_pulse = 0;
      if (all) begin m_lvl = !m_lvl; m_pulse = m_lvl; end
    end
  end

  // Monitor: pops an expected pulse whenever the DUT shows cpu_ce, and tracks visible state
  always @(negedge clk_50M) if (rst_n) begin
    exp_t e;
    tests++;
    if (state !== m_st || cycle_count !== m_cnt || led_tick !== m_led) begin
      fails++;
      $display("FAIL track cyc=%0d: state %0d want %0d, count %0h want %0h, led %b want %b",
               cyc, state, m_st, cycle_count, m_cnt, led_tick, m_led);
    end
    if (cpu_ce) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL ce_unexpected cyc=%0d: got cpu_ce=1 want no pulse", cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.cnt !== cycle_count || e.st !== state) begin
          fails++;
          $display("FAIL ce_pulse: got cyc=%0d count=%0h state=%0d want cyc=%0d count=%0h state=%0d",
                   cyc, cycle_count, state, e.cyc, e.cnt, e.st);
        end
      end
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL ce_missing: got no pulse at cyc=%0d want pulse", e.cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_ce(output int k);
    k = 0;
    do begin @(negedge clk_50M); k++; end while (!cpu_ce && k < 300);
  endtask

  task automatic btn_hold(input logic v, input int k, inout int c);
    repeat (k) begin step_btn = v; @(negedge clk_50M); c += int'(cpu_ce); end
  endtask

  initial begin
    repeat (3) @(negedge clk_50M);
    chk("rst_state", 32'(state), 32'(ST_HALTED));
    chk("rst_ce", 32'(cpu_ce), 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_led", 32'(led_tick), 0);
    rst_n = 1;
    repeat (2) @(negedge clk_50M);
    mode = MODE_FAST;
    ces = 0;
    repeat (10) begin @(negedge clk_50M); ces += int'(cpu_ce); end
    mode = MODE_HALT;
    @(negedge clk_50M);
    chk("fast_ce_cycles", 32'(ces), 10);
    chk("fast_count", cycle_count, 10);
    chk("fast_led", 32'(led_tick), 0);
    chk("fast_ce_off", 32'(cpu_ce), 0);
    mode = MODE_SLOW;
    wait_ce(n); chk("slow_first", 32'(n), 101);
    wait_ce(n); chk("slow_second", 32'(n), 100);
    repeat (37) @(negedge clk_50M);
    div_sel = 2'b11;
    wait_ce(n); chk("slow_divsel_switch", 32'(n), 11);
    wait_ce(n); chk("slow_10hz_period", 32'(n), 10);
    mode = MODE_STEP;
    repeat (3) @(negedge clk_50M);
    ces = 0;
    btn_hold(1, 1, ces); btn_hold(0, 1, ces); btn_hold(1, 7, ces); btn_hold(0, 8, ces);
    chk("step_bounce_one", 32'(ces), 1);
    ces = 0;
    btn_hold(1, 8, ces); btn_hold(0, 8, ces);
    chk("step_repress", 32'(ces), 1);
    mode = MODE_FAST;
    repeat (5) @(negedge clk_50M);
    @(posedge clk_50M);
    #2 rst_n = 0;
    #1;
    chk("async_rst_ce", 32'(cpu_ce), 0);
    chk("async_rst_count", cycle_count, 0);
    chk("async_rst_state", 32'(state), 32'(ST_HALTED));
    mode = MODE_HALT;
    @(negedge clk_50M);
    rst_n = 1;
    repeat (2) @(negedge clk_50M);
    mode = MODE_FAST;
    n = 0;
    do begin @(negedge clk_50M); n++; end while (cycle_count != 5 && n < 50);
    halt_req = 1;
    @(negedge clk_50M);
    halt_req = 0;
    chk("halt_state", 32'(state), 32'(ST_STOPPED));
    chk("halt_count", cycle_count, 6);
    chk("halt_ce", 32'(cpu_ce), 0);
    repeat (5) @(negedge clk_50M);
    chk("halt_frozen", cycle_count, 6);
    mode = MODE_STEP;
    repeat (3) @(negedge clk_50M);
    chk("stopped_sticky", 32'(state), 32'(ST_STOPPED));
    mode = MODE_HALT;
    repeat (2) @(negedge clk_50M);
    chk("stopped_exit", 32'(state), 32'(ST_HALTED));
    mode = MODE_FAST;
    repeat (2) @(negedge clk_50M);
    chk("resume_ce", 32'(cpu_ce), 1);
    mode = MODE_HALT;
    repeat (2) @(negedge clk_50M);
    force dut.cycle_count = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    @(negedge clk_50M);
    release dut.cycle_count;
    mode = MODE_FAST;
    repeat (3) @(negedge clk_50M);
    mode = MODE_HALT;
    repeat (2) @(negedge clk_50M);
    chk("saturate", cycle_count, 32'hFFFF_FFFF);
    for (int seg = 0; seg < 60; seg++) begin
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) div_sel = 2'($urandom_range(0, 3));
      repeat ($urandom_range(5, 120)) begin
        halt_req = $urandom_range(0, 24) == 0;
        if ($urandom_range(0, 5) == 0) step_btn = !step_btn;
        @(negedge clk_50M);
      end
    end
    halt_req = 0;
    mode = MODE_HALT;
    repeat (3) @(negedge clk_50M);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
